// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage iterative divider and its pipeline hooks.
package div_seq_pkg;

    // Architectural register width and pipeline control vector width.
    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned CTRL_WIDTH     = 6;

    // Position of the EX stage request in the controller's stall vector
    // (bit order: PC, IF, ID, EX, MEM, WB).
    localparam int unsigned STALL_EX_BIT   = 3;

    // Divider sequencer states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_BUSY = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift {rem, quo} left and trial-subtract.
module div_step
    import div_seq_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_WIDTH
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] shifted;
    logic            fits;

    // Partial remainder gains the next dividend bit; keep the difference if
    // the divisor fits, otherwise restore. The remainder stays below the
    // divisor, so the result always fits back into DATA_W bits.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        fits    = (shifted >= {1'b0, divisor});
        if (fits) begin
            rem_next = shifted[DATA_W-1:0] - divisor;
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end else begin
            rem_next = shifted[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// EX-stage DIV/DIVU sequencer: accepts one operation, runs DATA_W restoring
// iterations, stalls the pipeline while busy and holds {HI, LO} until EX moves on.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_WIDTH,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]   divisor,
    input  logic                cancel,
    output logic                stall_req,
    output logic                ready,
    output logic [2*DATA_W-1:0] result
);

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                neg_dvd_q;
    logic                neg_dvs_q;
    logic                signed_q;
    logic                ready_q;
    logic [2*DATA_W-1:0] result_q;

    logic [DATA_W-1:0]   rem_nx;
    logic [DATA_W-1:0]   quo_nx;
    logic                dvd_neg;
    logic                dvs_neg;
    logic [DATA_W-1:0]   dvd_abs;
    logic [DATA_W-1:0]   dvs_abs;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic                last_iter;

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // Operand magnitudes at accept; signs only matter for DIV.
    always_comb begin
        dvd_neg = signed_div & dividend[DATA_W-1];
        dvs_neg = signed_div & divisor[DATA_W-1];
        dvd_abs = dvd_neg ? -dividend : dividend;
        dvs_abs = dvs_neg ? -divisor  : divisor;
    end

    // Sign fix-up of the final iteration's output, written once into result.
    // The magnitude of -2^(DATA_W-1) negates back to itself, so the
    // overflow case -2^(DATA_W-1) / -1 needs no special handling.
    always_comb begin
        quo_fix   = (signed_q & (neg_dvd_q ^ neg_dvs_q)) ? -quo_nx : quo_nx;
        rem_fix   = (signed_q & neg_dvd_q) ? -rem_nx : rem_nx;
        last_iter = (cnt_q == CNT_W'(DATA_W - 1));
    end

    // Stall request to the pipeline controller; a flush always wins.
    always_comb begin
        stall_req = 1'b0;
        if (!cancel) begin
            stall_req = ((state_q == DIV_IDLE) && start) ||
                        (state_q == DIV_BUSY) ||
                        (state_q == DIV_ZERO);
        end
    end

    assign ready  = ready_q;
    assign result = result_q;

    // Sequencer: accept, iterate, publish result and hold it while EX stays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            signed_q  <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start && !cancel) begin
                        if (divisor != '0) begin
                            rem_q     <= '0;
                            quo_q     <= dvd_abs;
                            dvs_q     <= dvs_abs;
                            neg_dvd_q <= dvd_neg;
                            neg_dvs_q <= dvs_neg;
                            signed_q  <= signed_div;
                            cnt_q     <= '0;
                            state_q   <= DIV_BUSY;
                        end else begin
                            // Raw dividend parked in quo_q for the HI value.
                            quo_q   <= dividend;
                            state_q <= DIV_ZERO;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (cancel) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                            state_q  <= DIV_DONE;
                        end
                    end
                end
                DIV_ZERO: begin
                    if (cancel) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        result_q <= {quo_q, {DATA_W{1'b1}}};
                        ready_q  <= 1'b1;
                        state_q  <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!start || cancel) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq against a plain-arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall_req;
    logic        ready;
    logic [63:0] result;

    int n_asserts = 0;
    int n_fail    = 0;

    div_seq #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .stall_req  (stall_req),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Reference: MIPS DIV/DIVU semantics from language arithmetic in 64 bits.
    function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation with start held, scramble operands after accept,
    // check latency, stall, result, optional DONE hold, and release.
    task automatic run_div(input string tag, input bit sg, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        bit          stall_ok;
        exp     = model(sg, a, b);
        exp_lat = (b == 32'd0) ? 2 : 33;
        start = 1'b1; signed_div = sg; dividend = a; divisor = b; cancel = 1'b0;
        #1;
        check({tag, " stall_at_start"}, 64'(stall_req), 64'd1);
        lat = 0;
        stall_ok = 1'b1;
        while (!ready && lat < 40) begin
            tick();
            lat++;
            if (!ready && !stall_req) stall_ok = 1'b0;
            dividend   = $urandom;
            divisor    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stall_while_busy"}, 64'(stall_ok), 64'd1);
        check({tag, " stall_in_done"}, 64'(stall_req), 64'd0);
        check({tag, " result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold_ready"}, 64'(ready), 64'd1);
            check({tag, " hold_result"}, result, exp);
        end
        start = 1'b0;
        tick();
        check({tag, " ready_drop"}, 64'(ready), 64'd0);
        check({tag, " result_clear"}, result, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        bit          seen_ready;

        rst_n = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        check("reset stall", 64'(stall_req), 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 5);
        check("divu_100_7 literal", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_div("divu_by_zero", 1'b0, 32'h0000_1234, 32'd0, 2);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div("divu_small_big", 1'b0, 32'd3, 32'hFFFF_FFFF, 0);

        // Cancel after 10 BUSY iterations.
        start = 1'b1; signed_div = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd5;
        tick();
        repeat (10) tick();
        cancel = 1'b1;
        #1;
        check("cancel stall_drop", 64'(stall_req), 64'd0);
        tick();
        cancel = 1'b0; start = 1'b0;
        #1;
        check("cancel idle_stall", 64'(stall_req), 64'd0);
        seen_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ready) seen_ready = 1'b1;
        end
        check("cancel no_ready", 64'(seen_ready), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 0);

        // Start and cancel together in IDLE: nothing accepted.
        start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
        #1;
        check("start_cancel stall", 64'(stall_req), 64'd0);
        tick();
        start = 1'b0; cancel = 1'b0;
        #1;
        check("start_cancel not_busy", 64'(stall_req), 64'd0);
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready) seen_ready = 1'b1;
        end
        check("start_cancel no_ready", 64'(seen_ready), 64'd0);

        // Randomised operations.
        for (int n = 0; n < 24; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (n % 6 == 5) ra = $urandom_range(0, 100);
            run_div("random", rs, ra, rb, int'($urandom_range(0, 2)));
        end

        // Asynchronous reset mid-BUSY.
        start = 1'b1; signed_div = 1'b1; dividend = 32'h7654_3210; divisor = 32'd13;
        tick();
        repeat (5) tick();
        start = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy stall", 64'(stall_req), 64'd0);
        check("rst_busy ready", 64'(ready), 64'd0);
        check("rst_busy result", result, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset while holding a result in DONE.
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        repeat (33) tick();
        check("rst_done pre_ready", 64'(ready), 64'd1);
        check("rst_done pre_result", result, model(1'b0, 32'd1000, 32'd10));
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_done ready", 64'(ready), 64'd0);
        check("rst_done result", result, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative radix-2 divider sequencer serving the EX stage for DIV/DIVU.
- Accepts one operation from EX, runs 32 restoring-division iterations, and raises stall_req to the pipeline control unit while busy.
- Presents a 64-bit {remainder, quotient} result for the EX/MEM HI/LO write path.
- Can be cancelled by a pipeline flush at any time.

Parameters:
- DATA_W, 32, operand width; fixed to `REG_DATA_WIDTH.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  EX stage requests a divide; held high until EX leaves the instruction.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled at accept.
- dividend  in  DATA_W  rs operand; sampled at accept.
- divisor  in  DATA_W  rt operand; sampled at accept.
- cancel  in  1  flush of the EX stage; aborts any operation.
- stall_req  out  1  request to the pipeline controller to stall PC/IF/ID/EX.
- ready  out  1  result valid.
- result  out  2*DATA_W  {remainder (HI), quotient (LO)}; valid only while ready=1.

Behaviour:
- Reset: state=IDLE; counter, working registers, result all 0; ready=0, stall_req=0. Reset takes effect mid-operation with no completion.
- States: IDLE, DIV_ZERO, BUSY, DONE.
- IDLE:
  - start=1, cancel=0, divisor!=0: capture |dividend|, |divisor| (absolute values only when signed_div=1), the sign flags and signed_div. Next state BUSY, cnt=0.
  - start=1, cancel=0, divisor==0: next state DIV_ZERO.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle: shift {rem, quo} left one bit. Trial-subtract divisor from the upper DATA_W+1 bits. If the result is non-negative, keep the difference and set quo LSB=1; otherwise restore and set LSB=0. Then cnt++.
  - After the iteration with cnt=DATA_W-1, go to DONE.
  - cancel=1 in any BUSY cycle: go to IDLE next edge; the iteration in that cycle is discarded.
- DIV_ZERO: load result quotient=all ones, remainder=dividend as captured (team-defined value for MIPS-undefined behaviour). Go to DONE next edge; cancel=1 goes to IDLE instead.
- DONE:
  - ready=1.
  - Sign fix-up is applied once, on entry, into the result register: quotient negated if signed_div and the operand signs differ; remainder negated if signed_div and the dividend is negative.
  - Stay in DONE while start=1 and cancel=0. This covers EX held by a downstream stall: the result remains stable.
  - start=0 or cancel=1: go to IDLE, ready=0, result cleared to 0.
- stall_req is combinational: 1 when (IDLE and start and !cancel) or BUSY or DIV_ZERO; 0 in DONE and whenever cancel=1.
- Latency, counted from the first edge sampling start=1:
  - Normal divide: ready high after 33 edges (1 accept + 32 iterations).
  - Divide by zero: ready high after 2 edges.
- Arithmetic: -2^31 / -1 (signed) gives quotient 0x8000_0000, remainder 0; no trap.
- Operands presented after accept are ignored until the block returns to IDLE.
- Back-to-back operations: a new divide is accepted only from IDLE, so at least one idle cycle separates them. EX must drop start for one cycle between instructions; the pipeline controller guarantees this.
- cancel and start high in the same IDLE cycle: nothing is accepted.

Decomposition:
- Shared package/defines:
  - DIV_IDLE / DIV_ZERO / DIV_BUSY / DIV_DONE state encodings (2 bits).
  - `REG_DATA_WIDTH, `CTRL_WIDTH.
  - Stall-request bit position assigned to EX in the controller's request vector.
- One natural sub-module, div_step: a combinational single-iteration trial-subtract/shift (inputs rem, quo, divisor; outputs next rem, next quo). It is instantiated once; the FSM, counter and sign handling stay in div_seq.

Test Plan:
- DIVU 100/7, start held → stall_req high for 33 cycles, then ready=1, result={32'd2, 32'd14}, stall_req=0.
- DIV -7/2 signed → quotient 0xFFFF_FFFD (-3), remainder 0xFFFF_FFFF (-1); DIV 7/-2 → quotient -3, remainder 1.
- DIVU 0x1234/0 → ready after 2 edges, result={32'h0000_1234, 32'hFFFF_FFFF}.
- DIV 0x8000_0000 / 0xFFFF_FFFF signed → quotient 0x8000_0000, remainder 0, ready after 33 edges.
- Cancel at BUSY cycle 10 → IDLE next edge, stall_req=0, ready never asserts. A new DIVU 9/3 started two cycles later → result {0, 3} after 33 edges.
- In DONE with start held 5 extra cycles → ready and result stable. start dropped → ready=0 and result=0 next edge. rst_n pulsed low mid-BUSY → all outputs 0 immediately (asynchronous).
